regfile_mp: RTL and testbench

Parametrised multi-port integer register file, successor to the single-write core register file. Provides NR_READ combinational read ports with write-to-read bypass and NR_WRITE prioritised write ports. Adds a per-register scoreboard (busy bits) for issue-stage hazard checks and a req/gnt/rvalid debug port with a starvation counter that can stall the core. Sits between ID (reads, busy set) and EX/WB (writes), with the debug module as a third client.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_mp_if.sv | 28 ++
 rtl/regfile_dbg_arb.sv | 61 ++++++
 rtl/regfile_mp.sv | 124 ++++++++++++
 tb/tb_regfile_mp.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file and its debug arbiter.
package regfile_pkg;

    localparam int ADDR_W_DEF   = 5;
    localparam int DATA_W_DEF   = 32;
    localparam int PASS_REG_DEF = 27;
    localparam int DONE_REG_DEF = 26;

    // Same polarity as the core write-enable strobes
    localparam logic WriteEnable = 1'b1;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } dbg_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Debug access port of the register file: req/gnt/rvalid handshake plus the core stall request.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              dbg_req_i;
    logic              dbg_we_i;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [DATA_W-1:0] dbg_wdata_i;
    logic              dbg_gnt_o;
    logic              dbg_rvalid_o;
    logic [DATA_W-1:0] dbg_rdata_o;
    logic              dbg_stall_o;

    modport master (
        output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_stall_o
    );

    modport slave (
        input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_stall_o
    );

endinterface

// File: rtl/regfile_dbg_arb.sv
// Debug request arbiter: grants only when the core is not writing, and raises a stall
// request once a pending debug access has waited STARVE_MAX cycles.
module regfile_dbg_arb
    import regfile_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic core_we_i,
    output logic gnt_o,
    output logic rvalid_o,
    output logic stall_o
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    dbg_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             stall_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            stall_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            stall_reg <= (cnt_next == CNT_MAX);
        end
    end

    always_comb begin
        state_next = state_reg;
        gnt_o      = 1'b0;
        rvalid_o   = 1'b0;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                gnt_o = req_i & ~core_we_i;
                if (gnt_o) state_next = RESP;
            end
            RESP: begin
                rvalid_o   = 1'b1;
                state_next = IDLE;
            end
        endcase
        // Wait counter only runs while a request is actually being refused
        if (!req_i || gnt_o) begin
            cnt_next = '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    assign stall_o = stall_reg;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass, per-register busy bits
// and a debug access port that can stall the core when starved.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int NR_READ    = 2,
    parameter int NR_WRITE   = 2,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_MAX = 8,
    parameter int PASS_REG   = PASS_REG_DEF,
    parameter int DONE_REG   = DONE_REG_DEF
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NR_READ-1:0][ADDR_W-1:0]    raddr_i,
    output logic [NR_READ-1:0][DATA_W-1:0]    rdata_o,
    input  logic [NR_WRITE-1:0]               we_i,
    input  logic [NR_WRITE-1:0][ADDR_W-1:0]   waddr_i,
    input  logic [NR_WRITE-1:0][DATA_W-1:0]   wdata_i,
    input  logic                              busy_set_i,
    input  logic [ADDR_W-1:0]                 busy_addr_i,
    output logic [NR_READ-1:0]                busy_o,
    regfile_mp_if.slave                       dbg,
    output logic                              pass_o,
    output logic                              done_o
);

    localparam int NR_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]               regs_reg [NR_REGS];
    logic [NR_REGS-1:0]              busy_reg, busy_next;
    logic [NR_REGS-1:0]              wr_en, set_vec;
    logic [NR_REGS-1:0][DATA_W-1:0]  wr_data;
    logic [DATA_W-1:0]               dbg_rdata_reg;
    logic                            core_we, dbg_gnt, dbg_wr, dbg_rd;

    assign core_we = |we_i;

    regfile_dbg_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_dbg_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (dbg.dbg_req_i),
        .core_we_i (core_we),
        .gnt_o     (dbg_gnt),
        .rvalid_o  (dbg.dbg_rvalid_o),
        .stall_o   (dbg.dbg_stall_o)
    );

    assign dbg.dbg_gnt_o = dbg_gnt;
    assign dbg_wr = dbg_gnt & (dbg.dbg_we_i == WriteEnable);
    assign dbg_rd = dbg_gnt & (dbg.dbg_we_i != WriteEnable);

    // Debug grant implies no core write, so it never collides with the port loop below.
    // Ports are walked from the highest index down so the lowest index lands last.
    always_comb begin
        wr_en   = '0;
        wr_data = '0;
        if (dbg_wr) begin
            wr_en[dbg.dbg_addr_i]   = 1'b1;
            wr_data[dbg.dbg_addr_i] = dbg.dbg_wdata_i;
        end
        for (int w = NR_WRITE - 1; w >= 0; w--) begin
            if (we_i[w] == WriteEnable) begin
                wr_en[waddr_i[w]]   = 1'b1;
                wr_data[waddr_i[w]] = wdata_i[w];
            end
        end
        wr_en[0] = 1'b0;
    end

    always_comb begin
        set_vec              = '0;
        set_vec[busy_addr_i] = busy_set_i;
        // A set in the retirement cycle is a fresh issue, so it overrides the clear
        busy_next    = (busy_reg & ~wr_en) | set_vec;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_REGS; i++) regs_reg[i] <= '0;
            busy_reg <= '0;
        end else begin
            for (int i = 1; i < NR_REGS; i++) begin
                if (wr_en[i]) regs_reg[i] <= wr_data[i];
            end
            busy_reg <= busy_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dbg_rdata_reg <= '0;
        end else if (dbg_rd) begin
            dbg_rdata_reg <= regs_reg[dbg.dbg_addr_i];
        end
    end

    assign dbg.dbg_rdata_o = dbg_rdata_reg;

    for (genvar gi = 0; gi < NR_READ; gi++) begin : g_rd
        logic [DATA_W-1:0] byp_data;

        always_comb begin
            byp_data = regs_reg[raddr_i[gi]];
            for (int w = NR_WRITE - 1; w >= 0; w--) begin
                if ((we_i[w] == WriteEnable) && (waddr_i[w] == raddr_i[gi])) begin
                    byp_data = wdata_i[w];
                end
            end
        end

        assign rdata_o[gi] = (raddr_i[gi] == '0) ? '0 : byp_data;
        assign busy_o[gi]  = busy_reg[raddr_i[gi]]
                           & ~(wr_en[raddr_i[gi]] & ~set_vec[raddr_i[gi]]);
    end

    assign pass_o = ~regs_reg[PASS_REG][0];
    assign done_o = ~regs_reg[DONE_REG][0];

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed scenarios then random traffic against a
// per-cycle reference model; a negedge monitor pops and compares expected responses.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int NR_READ    = 2;
    localparam int NR_WRITE   = 2;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int STARVE_MAX = 8;
    localparam int PASS_REG   = 27;
    localparam int DONE_REG   = 26;
    localparam int NR_REGS    = 32;

    logic                            clk_i = 1'b0;
    logic                            rst_ni;
    logic [NR_READ-1:0][ADDR_W-1:0]  raddr_i;
    logic [NR_READ-1:0][DATA_W-1:0]  rdata_o;
    logic [NR_WRITE-1:0]             we_i;
    logic [NR_WRITE-1:0][ADDR_W-1:0] waddr_i;
    logic [NR_WRITE-1:0][DATA_W-1:0] wdata_i;
    logic                            busy_set_i;
    logic [ADDR_W-1:0]               busy_addr_i;
    logic [NR_READ-1:0]              busy_o;
    logic                            pass_o, done_o;

    regfile_mp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dbg_if ();

    regfile_mp #(
        .NR_READ(NR_READ), .NR_WRITE(NR_WRITE), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .STARVE_MAX(STARVE_MAX), .PASS_REG(PASS_REG), .DONE_REG(DONE_REG)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .raddr_i(raddr_i), .rdata_o(rdata_o),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .busy_set_i(busy_set_i), .busy_addr_i(busy_addr_i), .busy_o(busy_o),
        .dbg(dbg_if.slave),
        .pass_o(pass_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [NR_READ-1:0][DATA_W-1:0] rdata;
        logic [NR_READ-1:0]             busy;
        logic gnt, rvalid, stall, pass, done;
    } exp_t;

    typedef struct {
        logic              is_read;
        logic [DATA_W-1:0] data;
    } dbg_exp_t;

    exp_t     cyc_q[$];
    dbg_exp_t dbg_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: architectural registers, busy flags, owed debug response, wait length
    logic [DATA_W-1:0] m_mem [NR_REGS];
    bit                m_busy [NR_REGS];
    bit                m_resp_due;
    int                m_wait;
    bit                last_gnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Predict this cycle's outputs from the current inputs, then advance the model by one edge
    task automatic step();
        exp_t              e;
        logic [DATA_W-1:0] nxt_mem [NR_REGS];
        bit                claimed [NR_REGS];
        int                a;
        if (!rst_ni) begin
            for (int i = 0; i < NR_REGS; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
            m_resp_due = 1'b0;
            m_wait     = 0;
            dbg_q.delete();
        end
        e.gnt    = !m_resp_due && dbg_if.dbg_req_i && (we_i == '0);
        e.rvalid = m_resp_due;
        e.stall  = (m_wait == STARVE_MAX);
        e.pass   = ~m_mem[PASS_REG][0];
        e.done   = ~m_mem[DONE_REG][0];

        nxt_mem = m_mem;
        for (int i = 0; i < NR_REGS; i++) claimed[i] = 1'b0;
        for (int w = 0; w < NR_WRITE; w++) begin
            a = int'(waddr_i[w]);
            if (we_i[w] && a != 0 && !claimed[a]) begin
                claimed[a] = 1'b1;
                nxt_mem[a] = wdata_i[w];
            end
        end
        if (e.gnt && dbg_if.dbg_we_i && dbg_if.dbg_addr_i != '0) begin
            a = int'(dbg_if.dbg_addr_i);
            claimed[a] = 1'b1;
            nxt_mem[a] = dbg_if.dbg_wdata_i;
        end

        for (int r = 0; r < NR_READ; r++) begin
            a = int'(raddr_i[r]);
            e.rdata[r] = m_mem[a];
            if (a == 0) begin
                e.rdata[r] = '0;
            end else begin
                for (int w = 0; w < NR_WRITE; w++) begin
                    if (we_i[w] && int'(waddr_i[w]) == a) begin
                        e.rdata[r] = wdata_i[w];
                        break;
                    end
                end
            end
            e.busy[r] = m_busy[a] && !(claimed[a] && !(busy_set_i && int'(busy_addr_i) == a));
        end

        last_gnt = 1'b0;
        if (rst_ni) begin
            if (e.gnt) dbg_q.push_back('{is_read: !dbg_if.dbg_we_i, data: m_mem[dbg_if.dbg_addr_i]});
            m_mem = nxt_mem;
            for (int i = 1; i < NR_REGS; i++) begin
                if (claimed[i]) m_busy[i] = 1'b0;
                if (busy_set_i && int'(busy_addr_i) == i) m_busy[i] = 1'b1;
            end
            if (e.gnt || !dbg_if.dbg_req_i) m_wait = 0;
            else if (m_wait < STARVE_MAX) m_wait = m_wait + 1;
            m_resp_due = e.gnt;
            last_gnt   = e.gnt;
        end
        cyc_q.push_back(e);
    endtask

    task automatic cyc();
        step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        we_i = '0;
        busy_set_i = 1'b0;
        dbg_if.dbg_req_i = 1'b0;
    endtask

    // Monitor: compares every cycle's outputs, and the debug data whenever rvalid is shown
    initial begin
        exp_t     e;
        dbg_exp_t d;
        forever begin
            @(negedge clk_i);
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                for (int r = 0; r < NR_READ; r++) begin
                    chk($sformatf("rdata%0d", r), 64'(rdata_o[r]), 64'(e.rdata[r]));
                    chk($sformatf("busy%0d", r), 64'(busy_o[r]), 64'(e.busy[r]));
                end
                chk("dbg_gnt", 64'(dbg_if.dbg_gnt_o), 64'(e.gnt));
                chk("dbg_rvalid", 64'(dbg_if.dbg_rvalid_o), 64'(e.rvalid));
                chk("dbg_stall", 64'(dbg_if.dbg_stall_o), 64'(e.stall));
                chk("pass", 64'(pass_o), 64'(e.pass));
                chk("done", 64'(done_o), 64'(e.done));
            end
            if (dbg_if.dbg_rvalid_o === 1'b1) begin
                if (dbg_q.size() == 0) begin
                    chk("dbg_unexpected_rvalid", 64'(1), 64'(0));
                end else begin
                    d = dbg_q.pop_front();
                    if (d.is_read) chk("dbg_rdata", 64'(dbg_if.dbg_rdata_o), 64'(d.data));
                end
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        raddr_i = '0; we_i = '0; waddr_i = '0; wdata_i = '0;
        busy_set_i = 1'b0; busy_addr_i = '0;
        dbg_if.dbg_req_i = 1'b0; dbg_if.dbg_we_i = 1'b0;
        dbg_if.dbg_addr_i = '0; dbg_if.dbg_wdata_i = '0;
        m_resp_due = 1'b0; m_wait = 0; last_gnt = 1'b0;
        for (int i = 0; i < NR_REGS; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
        @(posedge clk_i); #1;
        cyc(); cyc();
        rst_ni = 1'b1;

        // Bypass then storage read of x5
        raddr_i[0] = 5'd5; raddr_i[1] = 5'd27;
        we_i = 2'b01; waddr_i[0] = 5'd5; wdata_i[0] = 32'hDEADBEEF;
        cyc(); idle(); cyc();

        // Both ports hit x7: port 0 wins
        raddr_i[1] = 5'd7;
        we_i = 2'b11; waddr_i[0] = 5'd7; waddr_i[1] = 5'd7;
        wdata_i[0] = 32'h11; wdata_i[1] = 32'h22;
        cyc(); idle(); cyc();

        // Busy set, clear by write, then set+write together
        raddr_i[0] = 5'd9;
        busy_set_i = 1'b1; busy_addr_i = 5'd9;
        cyc(); idle(); cyc();
        we_i = 2'b01; waddr_i[0] = 5'd9; wdata_i[0] = 32'h99;
        cyc(); idle(); cyc();
        busy_set_i = 1'b1; cyc();
        busy_set_i = 1'b1; we_i = 2'b10; waddr_i[1] = 5'd9; wdata_i[1] = 32'h123;
        cyc(); idle(); cyc();

        // Debug read of x3 with an idle core
        we_i = 2'b01; waddr_i[0] = 5'd3; wdata_i[0] = 32'hA5;
        cyc(); idle();
        dbg_if.dbg_req_i = 1'b1; dbg_if.dbg_we_i = 1'b0; dbg_if.dbg_addr_i = 5'd3;
        cyc(); idle(); cyc(); cyc();

        // Starvation: core keeps writing for 10 cycles, then yields
        dbg_if.dbg_req_i = 1'b1; dbg_if.dbg_addr_i = 5'd7;
        we_i = 2'b01; waddr_i[0] = 5'd10;
        for (int i = 0; i < 10; i++) begin
            wdata_i[0] = $urandom;
            cyc();
        end
        we_i = '0;
        cyc(); idle(); cyc(); cyc();

        // pass/done flags and the hardwired zero register
        raddr_i[0] = 5'd0; raddr_i[1] = 5'd27;
        we_i = 2'b11; waddr_i[0] = 5'd27; wdata_i[0] = 32'h1;
        waddr_i[1] = 5'd26; wdata_i[1] = 32'h3;
        cyc(); idle(); cyc();
        we_i = 2'b01; waddr_i[0] = 5'd0; wdata_i[0] = 32'hFFFF;
        cyc(); idle(); cyc();

        // Async reset while the debug response is owed
        dbg_if.dbg_req_i = 1'b1; dbg_if.dbg_we_i = 1'b0; dbg_if.dbg_addr_i = 5'd5;
        cyc(); idle();
        rst_ni = 1'b0;
        cyc(); cyc();
        rst_ni = 1'b1;
        cyc();

        // Random traffic
        for (int c = 0; c < 500; c++) begin
            for (int w = 0; w < NR_WRITE; w++) begin
                we_i[w]    = ($urandom_range(0, 1) == 1) && (m_wait != STARVE_MAX);
                waddr_i[w] = ADDR_W'($urandom_range(0, NR_REGS - 1));
                wdata_i[w] = $urandom;
            end
            if ($urandom_range(0, 3) == 0) waddr_i[1] = waddr_i[0];
            for (int r = 0; r < NR_READ; r++) begin
                raddr_i[r] = ($urandom_range(0, 1) == 1) ? waddr_i[r % NR_WRITE]
                                                          : ADDR_W'($urandom_range(0, NR_REGS - 1));
            end
            busy_set_i  = ($urandom_range(0, 3) == 0);
            busy_addr_i = ($urandom_range(0, 1) == 1) ? waddr_i[0] : ADDR_W'($urandom_range(0, NR_REGS - 1));
            if (last_gnt) begin
                dbg_if.dbg_req_i = 1'b0;
            end else if (!dbg_if.dbg_req_i && !m_resp_due && $urandom_range(0, 5) == 0) begin
                dbg_if.dbg_req_i   = 1'b1;
                dbg_if.dbg_we_i    = ($urandom_range(0, 2) == 0);
                dbg_if.dbg_addr_i  = ADDR_W'($urandom_range(0, NR_REGS - 1));
                dbg_if.dbg_wdata_i = $urandom;
            end
            cyc();
        end
        idle();
        cyc(); cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
